layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/nn_pkg.sv | 25 ++
 rtl/mac_sat.sv | 68 ++++++
 rtl/layer_sequencer.sv | 123 ++++++++++++
 tb/tb_layer_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared defaults, accumulator sizing and FSM state encoding for the layer sequencer.
package nn_pkg;

   localparam int unsigned N_DEF = 10;
   localparam int unsigned Q_DEF = 9;

   typedef enum logic [2:0] {
      IDLE,
      MAC,
      BIAS,
      OUT,
      DONE
   } state_t;

   // Wide enough to sum NI full products plus an aligned bias without wrapping
   function automatic int unsigned acc_width(input int unsigned n, input int unsigned ni);
      return 2 * n + $clog2(ni) + 2;
   endfunction

   // Address widths stay at least one bit so single-entry memories still get a port
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mac_sat.sv
// Multiply-accumulate datapath: product, accumulator, bias alignment, shift and clamp.
// Optional ReLU on the result is enabled by defining LAYER_SEQ_RELU_EN.
module mac_sat
   import nn_pkg::*;
#(
   parameter int unsigned N  = N_DEF,
   parameter int unsigned Q  = Q_DEF,
   parameter int unsigned NI = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                acc_en,
   input  logic                bias_en,
   input  logic signed [N-1:0] x_data,
   input  logic signed [N-1:0] w_data,
   input  logic signed [N-1:0] b_data,
   output logic        [N-1:0] y_data
);

   localparam int unsigned AW = acc_width(N, NI);
   localparam logic signed [AW-1:0] SMAX = AW'((64'd1 << (N - 1)) - 64'd1);
   localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);

   logic signed [2*N-1:0] prod;
   logic signed [AW-1:0]  prod_ext;
   logic signed [AW-1:0]  bias_al;
   logic signed [AW-1:0]  acc;
   logic signed [AW-1:0]  acc_sum;
   logic signed [AW-1:0]  shifted;
   logic        [N-1:0]   sat_val;
   logic        [N-1:0]   res;

   always_comb begin
      prod     = x_data * w_data;
      prod_ext = {{(AW - 2 * N){prod[2*N-1]}}, prod};
      bias_al  = {{(AW - N){b_data[N-1]}}, b_data} <<< Q;
      acc_sum  = acc + prod_ext + bias_al;
      shifted  = acc_sum >>> Q;
      if (shifted > SMAX) begin
         sat_val = SMAX[N-1:0];
      end else if (shifted < SMIN) begin
         sat_val = SMIN[N-1:0];
      end else begin
         sat_val = shifted[N-1:0];
      end
`ifdef LAYER_SEQ_RELU_EN
      res = sat_val[N-1] ? '0 : sat_val;
`else
      res = sat_val;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         y_data <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (bias_en) begin
         acc    <= acc_sum;
         y_data <= res;
      end else if (acc_en) begin
         acc <= acc + prod_ext;
      end
   end

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: per neuron NI MAC cycles, bias, then output strobe.
// Optional ReLU output (inside mac_sat) is enabled by defining LAYER_SEQ_RELU_EN.
module layer_sequencer
   import nn_pkg::*;
#(
   parameter int unsigned N  = N_DEF,
   parameter int unsigned Q  = Q_DEF,
   parameter int unsigned NI = 4,
   parameter int unsigned NN = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic [addr_width(NI)-1:0]     x_addr,
   input  logic [N-1:0]                  x_data,
   output logic [addr_width(NI*NN)-1:0]  w_addr,
   input  logic [N-1:0]                  w_data,
   output logic [addr_width(NN)-1:0]     b_addr,
   input  logic [N-1:0]                  b_data,
   output logic                          y_valid,
   output logic [addr_width(NN)-1:0]     y_addr,
   output logic [N-1:0]                  y_data,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned XW = addr_width(NI);
   localparam int unsigned WW = addr_width(NI * NN);
   localparam int unsigned BW = addr_width(NN);
   localparam logic [XW-1:0] K_LAST = XW'(NI - 1);
   localparam logic [BW-1:0] N_LAST = BW'(NN - 1);

   state_t        state, state_n;
   logic [XW-1:0] k;
   logic [BW-1:0] neuron;
   logic          clr, acc_en, bias_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         k      <= '0;
         neuron <= '0;
         y_addr <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (start) begin
                  k      <= '0;
                  neuron <= '0;
               end
            end
            MAC:  k <= (k == K_LAST) ? '0 : k + XW'(1);
            BIAS: y_addr <= neuron;
            OUT:  neuron <= (neuron == N_LAST) ? '0 : neuron + BW'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n = state;
      clr     = 1'b0;
      acc_en  = 1'b0;
      bias_en = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      y_valid = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = MAC;
               clr     = 1'b1;
            end
         end
         MAC: begin
            busy = 1'b1;
            // data returning in this cycle belongs to k-1, so k=0 has nothing yet
            acc_en = (k != '0);
            if (k == K_LAST) state_n = BIAS;
         end
         BIAS: begin
            busy    = 1'b1;
            bias_en = 1'b1;
            state_n = OUT;
         end
         OUT: begin
            busy    = 1'b1;
            y_valid = 1'b1;
            clr     = 1'b1;
            state_n = (neuron == N_LAST) ? DONE : MAC;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      x_addr = k;
      w_addr = WW'(32'(neuron) * NI + 32'(k));
      b_addr = neuron;
   end

   mac_sat #(
      .N (N),
      .Q (Q),
      .NI(NI)
   ) u_mac_sat (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .acc_en (acc_en),
      .bias_en(bias_en),
      .x_data (x_data),
      .w_data (w_data),
      .b_data (b_data),
      .y_data (y_data)
   );

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer (NI=2, NN=2, Q9 words): vector table plus corner sequences.
module tb_layer_sequencer;

   localparam int unsigned N  = 10;
   localparam int unsigned Q  = 9;
   localparam int unsigned NI = 2;
   localparam int unsigned NN = 2;
   localparam int          LAT = NN * (NI + 2);
   localparam int          NV  = 6;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [0:0] x_addr, b_addr, y_addr;
   logic [1:0] w_addr;
   logic [9:0] x_data, w_data, b_data, y_data;
   logic       y_valid, busy, done;

   always #5 clk = ~clk;

   layer_sequencer #(.N(N), .Q(Q), .NI(NI), .NN(NN)) dut (
      .clk(clk), .rst(rst), .start(start),
      .x_addr(x_addr), .x_data(x_data),
      .w_addr(w_addr), .w_data(w_data),
      .b_addr(b_addr), .b_data(b_data),
      .y_valid(y_valid), .y_addr(y_addr), .y_data(y_data),
      .busy(busy), .done(done)
   );

   // Synchronous memories: data one cycle after address
   logic [9:0] xm[2];
   logic [9:0] wm[4];
   logic [9:0] bm[2];
   always @(posedge clk) begin
      x_data <= xm[x_addr];
      w_data <= wm[w_addr];
      b_data <= bm[b_addr];
   end

   typedef struct {
      int w0, w1, w2, w3;
      int x0, x1;
      int b0, b1;
      int y0, y1;
   } vec_t;

   typedef struct packed {
      logic [0:0] addr;
      logic [9:0] data;
   } exp_t;

   vec_t tv[NV];
   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   function automatic int relu_exp(input int v);
`ifdef LAYER_SEQ_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic set_vec(input int i, input int w0, input int w1, input int w2, input int w3,
                          input int x0, input int x1, input int b0, input int b1,
                          input int y0, input int y1);
      tv[i].w0 = w0; tv[i].w1 = w1; tv[i].w2 = w2; tv[i].w3 = w3;
      tv[i].x0 = x0; tv[i].x1 = x1; tv[i].b0 = b0; tv[i].b1 = b1;
      tv[i].y0 = y0; tv[i].y1 = y1;
   endtask

   // Every sampling point goes through here so no y_valid slips by unchecked
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (y_valid) begin
         if (sbq.size() == 0) begin
            chk("unexpected_y_valid", 1, 0);
         end else begin
            e = sbq.pop_front();
            chk("y_addr", int'(y_addr), int'(e.addr));
            chk("y_data", int'($signed(y_data)), int'($signed(e.data)));
         end
      end
   endtask

   task automatic load(input int i, input int nexp);
      xm[0] = 10'(tv[i].x0); xm[1] = 10'(tv[i].x1);
      wm[0] = 10'(tv[i].w0); wm[1] = 10'(tv[i].w1);
      wm[2] = 10'(tv[i].w2); wm[3] = 10'(tv[i].w3);
      bm[0] = 10'(tv[i].b0); bm[1] = 10'(tv[i].b1);
      sbq.push_back('{addr: 1'b0, data: 10'(relu_exp(tv[i].y0))});
      if (nexp > 1) sbq.push_back('{addr: 1'b1, data: 10'(relu_exp(tv[i].y1))});
   endtask

   // Runs one layer with the table entry already loaded; extra>=0 re-pulses start at that cycle
   task automatic run_layer(input int i, input int extra);
      int c;
      int busy_bad;
      busy_bad = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (c = 0; c < 40; c++) begin
         tick();
         start = (c == extra);
         if (done) break;
         if (!busy) busy_bad++;
      end
      start = 1'b0;
      chk("done_latency", c, LAT);
      chk("busy_low_cycles", busy_bad, 0);
      chk("busy_at_done", int'(busy), 0);
      chk("y_data_hold", int'($signed(y_data)), relu_exp(tv[i].y1));
      chk("y_addr_hold", int'(y_addr), 1);
      chk("queue_drained", sbq.size(), 0);
   endtask

   initial begin
      int dcount, bcount;
      rst = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin xm[i] = '0; bm[i] = '0; end
      for (int i = 0; i < 4; i++) wm[i] = '0;

      //          w0    w1    w2    w3    x0    x1    b0    b1    y0    y1
      set_vec(0,  256,  256,  256,  256,  256,  256,    0,    0,  256,  256);
      set_vec(1,  256,  256,  256,  256,  256,  256,  128,  128,  384,  384);
      set_vec(2, -512, -512,    0,    0, -512, -512,    0, -512,  511, -512);
      set_vec(3, -512, -512,   -1,    0,  511,  511, -512,    0, -512,   -1);
      set_vec(4,    0,  256,  256,    0,  256,    0,    0,    0,    0,  128);
      set_vec(5,  200,   50,  -77,   13,  100,  -37,   -3,    7,   32,   -9);

      repeat (3) @(posedge clk);
      tick();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_y_valid", int'(y_valid), 0);
      chk("rst_y_data", int'(y_data), 0);
      chk("rst_y_addr", int'(y_addr), 0);
      chk("rst_x_addr", int'(x_addr), 0);
      chk("rst_w_addr", int'(w_addr), 0);
      chk("rst_b_addr", int'(b_addr), 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < NV; i++) begin
         load(i, 2);
         run_layer(i, -1);
         tick();
      end

      // start re-pulsed mid-layer: must be ignored, no second layer afterwards
      load(1, 2);
      run_layer(1, 3);
      bcount = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (busy) bcount++;
      end
      chk("no_requeued_layer", bcount, 0);

      // rst during the second neuron aborts the layer
      load(0, 1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      chk("abort_busy", int'(busy), 0);
      chk("abort_y_data", int'(y_data), 0);
      dcount = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (done) dcount++;
      end
      chk("abort_no_done", dcount, 0);
      chk("abort_queue", sbq.size(), 0);

      // rst wins over start in the same cycle
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start = 1'b0;
      bcount = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (busy) bcount++;
      end
      chk("rst_priority", bcount, 0);

      // normal run after abort
      load(5, 2);
      run_layer(5, -1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
